// File: rtl/rv_mul_iter.sv
// rv_mul_iter: iterative radix-2 shift-add multiplier for the RV64M multiply
// group (MUL, MULH, MULHSU, MULHU, MULW). Signs are stripped at accept time,
// an unsigned core retires one multiplier bit per clock, and the sign is
// re-applied in a final FIX cycle. Sits beside the sequential divider in EX.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   asynchronous, active-high
//   start   in   request; accepted only in IDLE or DONE
//   flush   in   synchronous abort, wins over start
//   op      in   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
//   op_w    in   1 = MULW (op ignored)
//   rs1     in   multiplicand
//   rs2     in   multiplier
//   busy    out  high in CALC and FIX
//   valid   out  one-cycle result strobe (DONE)
//   result  out  product slice, held until the next completed operation
module rv_mul_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic            op_w,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int AW = 2 * XLEN;
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [CW-1:0]   last_q,   last_d;
    logic [AW-1:0]   acc_q,    acc_d;
    logic [AW-1:0]   mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic            neg_q,    neg_d;
    logic [1:0]      op_q,     op_d;
    logic            opw_q,    opw_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            a_signed, b_signed;
    logic [XLEN-1:0] a_src, b_src;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   prod;

    // Magnitude of a possibly-signed operand; the most negative value maps
    // onto itself, which is the correct unsigned magnitude 2^(XLEN-1).
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                  input logic is_signed);
        return (is_signed && x[XLEN-1]) ? -x : x;
    endfunction

    function automatic logic [XLEN-1:0] select_slice(input logic [AW-1:0] p,
                                                     input logic [1:0] o,
                                                     input logic w);
        if (w)
            return {{(XLEN-32){p[31]}}, p[31:0]};
        else if (o == 2'b00)
            return p[XLEN-1:0];
        else
            return p[AW-1:XLEN];
    endfunction

    assign accept   = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
    assign a_signed = !op_w && (op == 2'b01 || op == 2'b10);
    assign b_signed = !op_w && (op == 2'b01);
    assign a_src    = op_w ? {{(XLEN-32){1'b0}}, rs1[31:0]} : rs1;
    assign b_src    = op_w ? {{(XLEN-32){1'b0}}, rs2[31:0]} : rs2;

    // The partial product of the current multiplier LSB is folded in here,
    // so the FIX edge also retires the final (N-1)th bit before negation.
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod     = neg_q ? -acc_sum : acc_sum;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        last_d   = last_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        op_d     = op_q;
        opw_d    = opw_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state_d  = S_CALC;
                        count_d  = '0;
                        last_d   = op_w ? CW'(31) : CW'(XLEN - 1);
                        acc_d    = '0;
                        mcand_d  = {{XLEN{1'b0}}, magnitude(a_src, a_signed)};
                        mplier_d = magnitude(b_src, b_signed);
                        neg_d    = (a_signed && rs1[XLEN-1]) ^ (b_signed && rs2[XLEN-1]);
                        op_d     = op;
                        opw_d    = op_w;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q + CW'(1) == last_q)
                        state_d = S_FIX;
                end
                S_FIX: begin
                    result_d = select_slice(prod, op_q, opw_q);
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            last_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            opw_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            opw_q    <= opw_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign valid  = (state_q == S_DONE);
    assign result = result_q;

endmodule
